fabric_stream_fifo: RTL and testbench
=====================================

# fabric_stream_fifo

- Parametrised elastic buffer for one `fabric_stream` valid/ready channel.
- Generalises the plain stream handshake with configurable data width, depth, and an optional same-cycle bypass mode.
- Adds an occupancy count, a synchronous flush and an optional high-water-mark monitor.
- Sits between fabric PEs and switches wherever a link needs slack or rate decoupling.

## Interface
Parameters:
- WIDTH, 32, payload bits per beat (>= 1)
- DEPTH, 4, entry count (>= 1, any integer, not restricted to powers of two)
- BYPASS, 0, 1 = fall-through when empty; 0 = fully registered output path
- CW, $clog2(DEPTH+1), width of occupancy outputs (derived, do not override)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset: synchronous, active-high
- flush  input  1  synchronous clear of all stored entries
- in_valid  input  1  upstream beat valid
- in_ready  output  1  FIFO accepts a beat this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  beat available downstream
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  downstream payload
- count  output  CW  stored entries, 0..DEPTH
- hwm  output  CW  maximum count since reset or flush

## Operation
- Storage: DEPTH-entry register array, write pointer wp, read pointer rp, each 0..DEPTH-1, plus count register.
- Pointer wrap: ptr == DEPTH-1 advances to 0. There is no power-of-two masking.
- push = in_valid & in_ready. pop = out_valid & out_ready & (count != 0).
- in_ready = !rst & !flush & (count != DEPTH). There is no combinational path from out_ready to in_ready.
- BYPASS=0:
  - out_valid = (count != 0).
  - out_data = mem[rp].
- BYPASS=1:
  - When count == 0, out_valid = in_valid & in_ready and out_data = in_data.
  - If out_ready is also high, the beat is delivered directly: no write, and wp/count are unchanged.
  - Otherwise the beat is stored normally.
  - When count != 0, behaviour is identical to BYPASS=0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Unchanged on a bypassed beat.
- Full (count == DEPTH): in_ready = 0, so push and pop cannot coincide. Pop proceeds normally.
- Empty (count == 0), BYPASS=0: out_valid = 0. A push becomes visible the next cycle.
- flush:
  - wp, rp and count are cleared to 0 and hwm is cleared to 0.
  - Concurrent in_valid is not accepted, because in_ready = 0.
  - out_valid is forced to 0 in that cycle.
- Priority: rst > flush > push/pop.
- out_data is don't-care whenever out_valid = 0.
- Memory contents are not reset.

## Timing
- Reset values:
  - in_ready = 0 while rst is high, then 1 in the first cycle after rst falls.
  - out_valid = 0, count = 0, hwm = 0, wp = rp = 0.
- Reset mid-operation: all stored beats are discarded within the reset cycle, with no partial handshake completing.
- Latency, BYPASS=0: exactly 1 cycle from push to out_valid when empty.
- Latency, BYPASS=1: 0 cycles (combinational) when empty and out_ready is high.
- Throughput: 1 beat per cycle sustained for DEPTH >= 2 in either mode.
  - DEPTH=1, BYPASS=0 gives half rate. This is a documented limitation, not a bug.
- count and hwm are registered and reflect the state after the previous edge.
- Handshake rules:
  - out_valid never drops while out_ready is low.
  - out_data is stable while out_valid is high and out_ready is low.

## Configuration
- FABRIC_STREAM_FIFO_HWM_EN defined:
  - hwm is a register updated each cycle to max(hwm, next count).
  - It saturates at DEPTH and is cleared by rst or flush.
- FABRIC_STREAM_FIFO_HWM_EN undefined:
  - hwm is tied to 0 and no register is inferred.
  - The port remains present so instantiations do not change.

## Test plan
- Reset/idle: hold rst 3 cycles, release.
  - During reset: in_ready=0, out_valid=0, count=0, hwm=0.
  - Cycle after release: in_ready=1.
- Fill/drain, WIDTH=8, DEPTH=3, BYPASS=0, out_ready=0:
  - Push 0x11, 0x22, 0x33, then offer 0x44 → in_ready=0 and count=3; 0x44 is not accepted.
  - Raise out_ready → out_data 0x11, 0x22, 0x33 on consecutive cycles; count reaches 0.
- Wrap and streaming, DEPTH=3: 10 beats 0..9 with both valid and ready held high.
  - After 1-cycle latency, outputs are 0..9 in order, with no bubbles.
  - Pointers wrap 2→0 at least three times.
- Bypass, BYPASS=1, empty, out_ready=1: push 0xA5.
  - out_valid=1 and out_data=0xA5 in the same cycle.
  - count stays 0.
  - With out_ready=0, 0xA5 is stored: count=1 next cycle.
- Flush collision: count=2 and flush=1 with in_valid=1 (data 0x7E).
  - In the flush cycle: in_ready=0 and out_valid=0.
  - Next cycle: count=0, hwm=0, and 0x7E never appears at the output.
- High-water mark with FABRIC_STREAM_FIFO_HWM_EN, DEPTH=4: push 3 beats, pop 2, push 1.
  - hwm=3 while count=2.
  - Without the macro, hwm=0 throughout.

Source files
------------

// File: rtl/fabric_stream_fifo.sv
// fabric_stream_fifo: elastic valid/ready buffer with optional fall-through bypass and occupancy/high-water outputs.
// Define FABRIC_STREAM_FIFO_HWM_EN to enable the high-water-mark register; otherwise hwm reads 0.
module fabric_stream_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    hwm
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt_n;
  logic empty, byp, push, pop, wr;
  assign empty     = (count == '0);
  assign byp       = (BYPASS != 0) && empty;
  assign in_ready  = !rst && !flush && (count != FULL);
  assign push      = in_valid && in_ready;
  assign out_valid = !rst && !flush && (empty ? (byp && push) : 1'b1);
  assign out_data  = byp ? in_data : mem[rp];
  assign pop       = out_valid && out_ready && !empty;
  // a beat handed straight through while empty is never written
  assign wr        = push && !(byp && out_ready);
  assign cnt_n     = count + CW'(wr) - CW'(pop);
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= (wp == LAST) ? '0 : wp + PW'(1);
      if (pop) rp <= (rp == LAST) ? '0 : rp + PW'(1);
      count <= cnt_n;
    end
  end
`ifdef FABRIC_STREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk) begin
    if (rst || flush) hwm_q <= '0;
    else if (cnt_n > hwm_q) hwm_q <= cnt_n;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif
endmodule

// File: tb/tb_fabric_stream_fifo.sv
// tb_fabric_stream_fifo: drives a DEPTH=3 registered FIFO and a DEPTH=4 bypass FIFO with shared stimulus, scoreboarded against queue models.
module tb_fabric_stream_fifo;
`ifdef FABRIC_STREAM_FIFO_HWM_EN
  localparam bit HWM = 1'b1;
`else
  localparam bit HWM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic ir0, ir1, ov0, ov1;
  logic [7:0] od0, od1;
  logic [1:0] c0, h0;
  logic [2:0] c1, h1;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int mh [2];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fabric_stream_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .count(c0), .hwm(h0));
  fabric_stream_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(c1), .hwm(h1));
  function automatic int qs(int k);
    return (k != 0) ? q1.size() : q0.size();
  endfunction
  task automatic chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", nm, k, a, e, $time);
    end
  endtask
  // at each edge the model queue holds exactly the beats the FIFO should be storing
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    rst = 1'b0; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      int n, dp, nn;
      bit acc, eov;
      n = qs(k);
      dp = (k != 0) ? 4 : 3;
      acc = iv && !fl && (n != dp);
      eov = !fl && (n != 0 || (k == 1 && acc));
      chk("in_ready", k, 32'((k != 0) ? ir1 : ir0), 32'(!fl && n != dp));
      chk("out_valid", k, 32'((k != 0) ? ov1 : ov0), 32'(eov));
      chk("count", k, (k != 0) ? 32'(c1) : 32'(c0), 32'(n));
      chk("hwm", k, (k != 0) ? 32'(h1) : 32'(h0), 32'(mh[k]));
      if (fl) begin
        if (k != 0) q1.delete(); else q0.delete();
      end else if (acc) begin
        if (k != 0) q1.push_back(d); else q0.push_back(d);
      end
      nn = fl ? 0 : n + int'(acc) - int'(eov && ordy);
      mh[k] = fl ? 0 : (HWM && nn > mh[k]) ? nn : mh[k];
    end
  endtask
  task automatic do_reset(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'($urandom); in_data = 8'($urandom); out_ready = 1'($urandom); flush = 1'b0;
      #1;
      chk("rst_in_ready", 0, 32'(ir0), 0);
      chk("rst_in_ready", 1, 32'(ir1), 0);
      chk("rst_out_valid", 0, 32'(ov0), 0);
      chk("rst_out_valid", 1, 32'(ov1), 0);
      if (i > 0) begin
        chk("rst_count", 0, 32'(c0), 0);
        chk("rst_count", 1, 32'(c1), 0);
        chk("rst_hwm", 0, 32'(h0), 0);
        chk("rst_hwm", 1, 32'(h1), 0);
      end
      q0.delete(); q1.delete(); mh[0] = 0; mh[1] = 0;
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst && ov0 && out_ready) begin
      if (q0.size() == 0) chk("unexpected_beat", 0, 32'(od0), 32'hFFFF_FFFF);
      else chk("out_data", 0, 32'(od0), 32'(q0.pop_front()));
    end
    if (!rst && ov1 && out_ready) begin
      if (q1.size() == 0) chk("unexpected_beat", 1, 32'(od1), 32'hFFFF_FFFF);
      else chk("out_data", 1, 32'(od1), 32'(q1.pop_front()));
    end
  end
  initial begin
    mh[0] = 0; mh[1] = 0;
    do_reset(3);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 250) == 0) do_reset(2);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
